// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator (R/I/S/B/U/J) with valid/ready on both sides.
// Define IMM_GEN_SKID_EN to add a one-entry skid buffer so in_ready becomes a pure register output.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immidiate,
    output logic [4:0]      A3,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam int PW = XLEN + 9;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic            w_isShift;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_rd;
    logic [PW-1:0]   w_dec;
    logic            w_inFire;
    logic            w_outFire;
    logic [PW-1:0]   r_out;
    logic            r_outValid;

    always_comb begin
        w_fmt     = FMT_ILL;
        w_illegal = 1'b0;
        case (instruction[6:0])
            OP_LUI, OP_AUIPC:                      w_fmt = FMT_U;
            OP_JAL:                                w_fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM: w_fmt = FMT_I;
            OP_STORE:                              w_fmt = FMT_S;
            OP_BRANCH:                             w_fmt = FMT_B;
            OP_OP:                                 w_fmt = FMT_R;
            default: begin
                w_fmt     = FMT_ILL;
                w_illegal = 1'b1;
            end
        endcase
    end

    // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a zero-extended shift amount instead of an immediate
    assign w_isShift = (instruction[6:0] == OP_OPIMM) && (instruction[13:12] == 2'b01);

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I: begin
                if (w_isShift) begin
                    w_imm32 = {{(32-SHAMT_W){1'b0}}, instruction[20 +: SHAMT_W]};
                end else begin
                    w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
                end
            end
            FMT_S: w_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            FMT_B: w_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
            FMT_U: w_imm32 = {instruction[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_narrow
            assign w_imm = w_imm32;
        end
    endgenerate

    assign w_rd  = (w_fmt == FMT_S || w_fmt == FMT_B || w_illegal) ? 5'd0 : instruction[11:7];
    assign w_dec = {w_imm, w_rd, w_fmt, w_illegal};

    assign {immidiate, A3, fmt, illegal} = r_out;
    assign out_valid = r_outValid;
    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = r_outValid && out_ready;

`ifdef IMM_GEN_SKID_EN
    logic [PW-1:0] r_skid;
    logic          r_skidValid;

    assign in_ready = !r_skidValid;

    // Skid is only filled while the output stalls, so it always holds the younger word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_outValid  <= 1'b0;
            r_skid      <= '0;
            r_skidValid <= 1'b0;
        end else begin
            if (!r_outValid || w_outFire) begin
                if (r_skidValid) begin
                    r_out       <= r_skid;
                    r_outValid  <= 1'b1;
                    r_skidValid <= 1'b0;
                end else if (w_inFire) begin
                    r_out      <= w_dec;
                    r_outValid <= 1'b1;
                end else begin
                    r_outValid <= 1'b0;
                end
            end else if (w_inFire) begin
                r_skid      <= w_dec;
                r_skidValid <= 1'b1;
            end
        end
    end
`else
    assign in_ready = !r_outValid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_outValid <= 1'b0;
        end else if (w_inFire) begin
            r_out      <= w_dec;
            r_outValid <= 1'b1;
        end else if (w_outFire) begin
            r_outValid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: randomized and directed checks of imm_gen_pipe against a behavioural decode model.
// Instantiates an XLEN=32 and an XLEN=64 copy; honours IMM_GEN_SKID_EN for ready expectations.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] instr32, imm32;
    logic [4:0]  a3_32;
    logic [2:0]  fmt32;
    logic        ill32;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [31:0] instr64;
    logic [63:0] imm64;
    logic [4:0]  a3_64;
    logic [2:0]  fmt64;
    logic        ill64;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [2:0]  f;
        logic        ill;
    } exp_t;

    imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .instruction(instr32), .out_valid(out_valid32), .out_ready(out_ready32),
        .immidiate(imm32), .A3(a3_32), .fmt(fmt32), .illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .SHAMT_W(6)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .instruction(instr64), .out_valid(out_valid64), .out_ready(out_ready64),
        .immidiate(imm64), .A3(a3_64), .fmt(fmt64), .illegal(ill64)
    );

    // Reference decode built from field values with plain integer arithmetic
    function automatic exp_t ref_decode(input logic [31:0] inst, input int xlen, input int shamtw);
        exp_t e;
        longint v;
        logic [6:0] op;
        logic [2:0] f3;
        op = inst[6:0];
        f3 = inst[14:12];
        v = 0;
        e.ill = 1'b0;
        case (op)
            7'h37, 7'h17:               e.f = 3'd4;
            7'h6F:                      e.f = 3'd5;
            7'h67, 7'h03, 7'h13, 7'h73: e.f = 3'd1;
            7'h23:                      e.f = 3'd2;
            7'h63:                      e.f = 3'd3;
            7'h33:                      e.f = 3'd0;
            default: begin
                e.f = 3'd7;
                e.ill = 1'b1;
            end
        endcase
        case (e.f)
            3'd1: begin
                v = longint'(inst[31:20]);
                if (v >= 2048) v -= 4096;
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
                    v = longint'(inst >> 20) % (longint'(1) << shamtw);
            end
            3'd2: begin
                v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
                if (v >= 2048) v -= 4096;
            end
            3'd3: begin
                v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                  + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd4: begin
                v = longint'(inst[31:12]) * 4096;
                if (inst[31]) v -= (longint'(1) << 32);
            end
            3'd5: begin
                v = longint'(inst[31]) * (longint'(1) << 20) + longint'(inst[19:12]) * 4096
                  + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
            end
            default: v = 0;
        endcase
        e.imm = (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
        e.rd  = (e.f == 3'd0 || e.f == 3'd1 || e.f == 3'd4 || e.f == 3'd5) ? inst[11:7] : 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [6:0]  legal [10];
        logic [6:0]  bad [6];
        logic [31:0] inst;
        int k;
        legal = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h23, 7'h63, 7'h33};
        bad   = '{7'h7F, 7'h0B, 7'h2B, 7'h5B, 7'h0F, 7'h00};
        inst = $urandom;
        k = $urandom_range(0, 11);
        if (k < 10) inst[6:0] = legal[k];
        else        inst[6:0] = bad[$urandom_range(0, 5)];
        return inst;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (out_valid32 !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid32); else passes++;
        checks++; if ({imm32, a3_32, fmt32, ill32} !== '0) $display("[TB] FAIL reset_outputs: got imm=%h A3=%0d fmt=%0d ill=%0b want all 0", imm32, a3_32, fmt32, ill32); else passes++;
        checks++; if (out_valid64 !== 1'b0 || imm64 !== 64'd0) $display("[TB] FAIL reset_64: got valid=%0b imm=%h want 0/0", out_valid64, imm64); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (in_ready32 !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready32); else passes++;
    endtask

    task automatic test_directed_decode();
        logic [31:0] dInst [4];
        logic [31:0] dImm [4];
        logic [4:0]  dRd [4];
        logic [2:0]  dFmt [4];
        logic        dIll [4];
        dInst = '{32'h123450B7, 32'hFFF00093, 32'hFE000EE3, 32'h0000007F};
        dImm  = '{32'h12345000, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000000};
        dRd   = '{5'd1, 5'd1, 5'd0, 5'd0};
        dFmt  = '{3'd4, 3'd1, 3'd3, 3'd7};
        dIll  = '{1'b0, 1'b0, 1'b0, 1'b1};
        out_ready32 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid32 = 1'b1;
            instr32 = dInst[i];
            step();
            in_valid32 = 1'b0;
            checks++; if (out_valid32 !== 1'b1) $display("[TB] FAIL dir%0d_valid: got %0b want 1", i, out_valid32); else passes++;
            checks++; if (imm32 !== dImm[i]) $display("[TB] FAIL dir%0d_imm: got %h want %h", i, imm32, dImm[i]); else passes++;
            checks++; if (a3_32 !== dRd[i]) $display("[TB] FAIL dir%0d_A3: got %0d want %0d", i, a3_32, dRd[i]); else passes++;
            checks++; if (fmt32 !== dFmt[i] || ill32 !== dIll[i]) $display("[TB] FAIL dir%0d_fmt: got fmt=%0d ill=%0b want fmt=%0d ill=%0b", i, fmt32, ill32, dFmt[i], dIll[i]); else passes++;
            step();
            checks++; if (out_valid32 !== 1'b0) $display("[TB] FAIL dir%0d_drain: got %0b want 0", i, out_valid32); else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic bAccepted;
        logic expReadyStall;
        bAccepted = 1'b0;
`ifdef IMM_GEN_SKID_EN
        expReadyStall = 1'b1;
`else
        expReadyStall = 1'b0;
`endif
        out_ready32 = 1'b0;
        in_valid32 = 1'b1;
        instr32 = 32'h123450B7;
        #1;
        checks++; if (in_ready32 !== 1'b1) $display("[TB] FAIL bp_ready_idle: got %0b want 1", in_ready32); else passes++;
        step();
        instr32 = 32'hFFF00093;
        #1;
        checks++; if (in_ready32 !== expReadyStall) $display("[TB] FAIL bp_ready_first_stall: got %0b want %0b", in_ready32, expReadyStall); else passes++;
        for (int c = 0; c < 3; c++) begin
            if (in_valid32 && in_ready32) bAccepted = 1'b1;
            step();
            if (bAccepted) in_valid32 = 1'b0;
            #1;
            checks++; if (out_valid32 !== 1'b1 || imm32 !== 32'h12345000) $display("[TB] FAIL bp_hold%0d: got valid=%0b imm=%h want 1/12345000", c, out_valid32, imm32); else passes++;
            checks++; if (in_ready32 !== 1'b0) $display("[TB] FAIL bp_ready_hold%0d: got %0b want 0", c, in_ready32); else passes++;
        end
        out_ready32 = 1'b1;
        #1;
        if (in_valid32 && in_ready32) bAccepted = 1'b1;
        step();
        in_valid32 = 1'b0;
        checks++; if (out_valid32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || fmt32 !== 3'd1) $display("[TB] FAIL bp_second: got valid=%0b imm=%h fmt=%0d want 1/ffffffff/1", out_valid32, imm32, fmt32); else passes++;
        checks++; if (bAccepted !== 1'b1) $display("[TB] FAIL bp_second_accepted: got %0b want 1", bAccepted); else passes++;
        step();
        checks++; if (out_valid32 !== 1'b0) $display("[TB] FAIL bp_drain: got %0b want 0", out_valid32); else passes++;
    endtask

    task automatic test_mid_reset();
        out_ready32 = 1'b0;
        in_valid32 = 1'b1;
        instr32 = 32'h123450B7;
        step();
        rst = 1'b1;
        instr32 = 32'hFFF00093;
        step();
        checks++; if (out_valid32 !== 1'b0 || {imm32, a3_32, fmt32, ill32} !== '0) $display("[TB] FAIL midrst_clear: got valid=%0b imm=%h A3=%0d fmt=%0d ill=%0b want all 0", out_valid32, imm32, a3_32, fmt32, ill32); else passes++;
        rst = 1'b0;
        in_valid32 = 1'b0;
        #1;
        checks++; if (in_ready32 !== 1'b1) $display("[TB] FAIL midrst_ready: got %0b want 1", in_ready32); else passes++;
        step();
        checks++; if (out_valid32 !== 1'b0) $display("[TB] FAIL midrst_no_ghost: got %0b want 0", out_valid32); else passes++;
        out_ready32 = 1'b1;
    endtask

    task automatic test_xlen64();
        exp_t e;
        logic prevValid;
        logic [31:0] prevInst;
        out_ready64 = 1'b1;
        in_valid64 = 1'b1;
        instr64 = 32'hFFDFF0EF;
        step();
        checks++; if (out_valid64 !== 1'b1 || imm64 !== 64'hFFFFFFFFFFFFFFFC || a3_64 !== 5'd1 || fmt64 !== 3'd5) $display("[TB] FAIL x64_jal: got valid=%0b imm=%h A3=%0d fmt=%0d want 1/fffffffffffffffc/1/5", out_valid64, imm64, a3_64, fmt64); else passes++;
        instr64 = 32'h03F09093;
        step();
        checks++; if (imm64 !== 64'h3F || fmt64 !== 3'd1) $display("[TB] FAIL x64_slli: got imm=%h fmt=%0d want 3f/1", imm64, fmt64); else passes++;
        prevValid = 1'b0;
        prevInst = '0;
        for (int c = 0; c < 300; c++) begin
            in_valid64 = ($urandom_range(0, 3) != 0);
            instr64 = gen_inst();
            prevValid = in_valid64;
            prevInst = instr64;
            step();
            e = ref_decode(prevInst, 64, 6);
            checks++; if (out_valid64 !== prevValid) $display("[TB] FAIL x64_rand_valid: got %0b want %0b", out_valid64, prevValid); else passes++;
            if (prevValid) begin
                checks++; if ({imm64, a3_64, fmt64, ill64} !== {e.imm, e.rd, e.f, e.ill}) $display("[TB] FAIL x64_rand_data inst=%h: got imm=%h A3=%0d fmt=%0d ill=%0b want imm=%h A3=%0d fmt=%0d ill=%0b", prevInst, imm64, a3_64, fmt64, ill64, e.imm, e.rd, e.f, e.ill); else passes++;
            end
        end
        in_valid64 = 1'b0;
    endtask

    task automatic test_random_stream();
        exp_t q[$];
        exp_t e;
        logic expReady;
        logic inFire;
        logic outFire;
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            in_valid32 = ($urandom_range(0, 3) != 0);
            instr32 = gen_inst();
            out_ready32 = ($urandom_range(0, 2) != 0);
            #1;
`ifdef IMM_GEN_SKID_EN
            expReady = (q.size() < 2);
`else
            expReady = (q.size() == 0) || out_ready32;
`endif
            checks++; if (out_valid32 !== (q.size() > 0)) $display("[TB] FAIL rnd_valid cyc%0d: got %0b want %0b", c, out_valid32, q.size() > 0); else passes++;
            checks++; if (in_ready32 !== expReady) $display("[TB] FAIL rnd_ready cyc%0d: got %0b want %0b", c, in_ready32, expReady); else passes++;
            if (q.size() > 0) begin
                checks++; if ({imm32, a3_32, fmt32, ill32} !== {q[0].imm[31:0], q[0].rd, q[0].f, q[0].ill}) $display("[TB] FAIL rnd_data cyc%0d: got imm=%h A3=%0d fmt=%0d ill=%0b want imm=%h A3=%0d fmt=%0d ill=%0b", c, imm32, a3_32, fmt32, ill32, q[0].imm[31:0], q[0].rd, q[0].f, q[0].ill); else passes++;
            end
            inFire = in_valid32 && expReady;
            outFire = (q.size() > 0) && out_ready32;
            e = ref_decode(instr32, 32, 5);
            step();
            if (outFire) void'(q.pop_front());
            if (inFire) q.push_back(e);
        end
        in_valid32 = 1'b0;
        out_ready32 = 1'b1;
        for (int c = 0; c < 4; c++) step();
        checks++; if (out_valid32 !== 1'b0) $display("[TB] FAIL rnd_final_drain: got %0b want 0", out_valid32); else passes++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid32 = 1'b0; instr32 = '0; out_ready32 = 1'b1;
        in_valid64 = 1'b0; instr64 = '0; out_ready64 = 1'b1;
        test_reset();
        test_directed_decode();
        test_backpressure();
        test_mid_reset();
        test_xlen64();
        test_random_stream();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
